// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter letting two requesters share one
//               single-port synchronous RAM; returns read data to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int addr_bits = 16,
  parameter int data_bits = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_req,
  input  logic                 a_write,
  input  logic [addr_bits-1:0] a_address,
  input  logic [data_bits-1:0] a_wdata,
  output logic                 a_grant,
  output logic                 a_rvalid,
  output logic [data_bits-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_write,
  input  logic [addr_bits-1:0] b_address,
  input  logic [data_bits-1:0] b_wdata,
  output logic                 b_grant,
  output logic                 b_rvalid,
  output logic [data_bits-1:0] b_rdata,
  output logic                 ram_write_enable,
  output logic [addr_bits-1:0] ram_address,
  output logic [data_bits-1:0] ram_data_in,
  input  logic [data_bits-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2
  } state_t;

  localparam logic c_req_a = 1'b0;
  localparam logic c_req_b = 1'b1;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last;
  logic                 r_owner;
  logic                 r_write;
  logic                 r_a_grant;
  logic                 r_b_grant;
  logic                 r_a_rvalid;
  logic                 r_b_rvalid;
  logic [data_bits-1:0] r_a_rdata;
  logic [data_bits-1:0] r_b_rdata;
  logic                 r_ram_write_enable;
  logic [addr_bits-1:0] r_ram_address;
  logic [data_bits-1:0] r_ram_data_in;
  logic                 w_start;
  logic                 w_pick_b;
  logic                 w_win_write;

  // B wins only when A is idle or A was the last one served.
  assign w_pick_b    = b_req & (~a_req | (r_last == c_req_a));
  assign w_win_write = w_pick_b ? b_write : a_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req | b_req) begin
          w_start      = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next_state = r_write ? S_IDLE : S_READ;
      end
      S_READ: begin
        // Arbitrating here lets the next command overlap the rvalid pulse.
        if (a_req | b_req) begin
          w_start      = 1'b1;
          w_next_state = S_ACCESS;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last             <= c_req_b;
      r_owner            <= c_req_a;
      r_write            <= 1'b0;
      r_a_grant          <= 1'b0;
      r_b_grant          <= 1'b0;
      r_a_rvalid         <= 1'b0;
      r_b_rvalid         <= 1'b0;
      r_a_rdata          <= '0;
      r_b_rdata          <= '0;
      r_ram_write_enable <= 1'b0;
      r_ram_address      <= '0;
      r_ram_data_in      <= '0;
    end else begin
      r_a_grant          <= w_start & ~w_pick_b;
      r_b_grant          <= w_start & w_pick_b;
      r_ram_write_enable <= w_start & w_win_write;
      if (w_start) begin
        r_owner       <= w_pick_b;
        r_last        <= w_pick_b;
        r_write       <= w_win_write;
        r_ram_address <= w_pick_b ? b_address : a_address;
        r_ram_data_in <= w_pick_b ? b_wdata : a_wdata;
      end
      r_a_rvalid <= (r_state == S_READ) && (r_owner == c_req_a);
      r_b_rvalid <= (r_state == S_READ) && (r_owner == c_req_b);
      if ((r_state == S_READ) && (r_owner == c_req_a)) begin
        r_a_rdata <= ram_data_out;
      end
      if ((r_state == S_READ) && (r_owner == c_req_b)) begin
        r_b_rdata <= ram_data_out;
      end
    end
  end

  assign a_grant          = r_a_grant;
  assign b_grant          = r_b_grant;
  assign a_rvalid         = r_a_rvalid;
  assign b_rvalid         = r_b_rvalid;
  assign a_rdata          = r_a_rdata;
  assign b_rdata          = r_b_rdata;
  assign ram_write_enable = r_ram_write_enable;
  assign ram_address      = r_ram_address;
  assign ram_data_in      = r_ram_data_in;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed, table-driven bench for ram_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clock;
  logic        reset_n;
  logic        a_req, a_write, b_req, b_write;
  logic [15:0] a_address, b_address;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_grant, a_rvalid, b_grant, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        ram_write_enable;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_in, ram_data_out;

  logic [7:0]  mem [0:65535];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ar, aw;
    logic [15:0] aa;
    logic [7:0]  ad;
    logic        br, bw;
    logic [15:0] ba;
    logic [7:0]  bd;
    logic [44:0] exp;
  } vec_t;

  vec_t vecs[$];

  ram_arbiter #(.addr_bits(16), .data_bits(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
    .a_grant(a_grant), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
    .b_grant(b_grant), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single-port synchronous RAM, registered read.
  always @(posedge clock) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  function automatic logic [44:0] outs();
    return {a_grant, b_grant, a_rvalid, b_rvalid, a_rdata, b_rdata,
            ram_write_enable, ram_address, ram_data_in};
  endfunction

  function automatic logic [44:0] mk(input logic ag, bg, av, bv,
                                     input logic [7:0] ard, brd,
                                     input logic we, input logic [15:0] ra,
                                     input logic [7:0] rd);
    return {ag, bg, av, bv, ard, brd, we, ra, rd};
  endfunction

  task automatic add(input logic ar, aw, input logic [15:0] aa, input logic [7:0] ad,
                     input logic br, bw, input logic [15:0] ba, input logic [7:0] bd,
                     input logic [44:0] e);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [44:0] act, input logic [44:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, aw, input logic [15:0] aa, input logic [7:0] ad,
                       input logic br, bw, input logic [15:0] ba, input logic [7:0] bd);
    a_req = ar; a_write = aw; a_address = aa; a_wdata = ad;
    b_req = br; b_write = bw; b_address = ba; b_wdata = bd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h77;
    mem[16'h0010] = 8'h5A;
    mem[16'h0020] = 8'h11;
    mem[16'h0030] = 8'h22;
    mem[16'h0040] = 8'h33;
    mem[16'h0050] = 8'h44;

    // single read by A
    add(1,0,16'h0010,0, 0,0,0,0, mk(1,0,0,0,8'h00,8'h00,0,16'h0010,8'h00));
    add(0,0,0,0,        0,0,0,0, mk(0,0,0,0,8'h00,8'h00,0,16'h0010,8'h00));
    add(0,0,0,0,        0,0,0,0, mk(0,0,1,0,8'h5A,8'h00,0,16'h0010,8'h00));
    add(0,0,0,0,        0,0,0,0, mk(0,0,0,0,8'h5A,8'h00,0,16'h0010,8'h00));
    // B write then read back
    add(0,0,0,0, 1,1,16'h1234,8'h3C, mk(0,1,0,0,8'h5A,8'h00,1,16'h1234,8'h3C));
    add(0,0,0,0, 0,0,0,0,            mk(0,0,0,0,8'h5A,8'h00,0,16'h1234,8'h3C));
    add(0,0,0,0, 1,0,16'h1234,8'h00, mk(0,1,0,0,8'h5A,8'h00,0,16'h1234,8'h00));
    add(0,0,0,0, 0,0,0,0,            mk(0,0,0,0,8'h5A,8'h00,0,16'h1234,8'h00));
    add(0,0,0,0, 0,0,0,0,            mk(0,0,0,1,8'h5A,8'h3C,0,16'h1234,8'h00));
    add(0,0,0,0, 0,0,0,0,            mk(0,0,0,0,8'h5A,8'h3C,0,16'h1234,8'h00));
    // contention and back-to-back reads
    add(1,0,16'h0020,0, 1,0,16'h0030,0, mk(1,0,0,0,8'h5A,8'h3C,0,16'h0020,8'h00));
    add(0,0,0,0,        1,0,16'h0030,0, mk(0,0,0,0,8'h5A,8'h3C,0,16'h0020,8'h00));
    add(0,0,0,0,        1,0,16'h0030,0, mk(0,1,1,0,8'h11,8'h3C,0,16'h0030,8'h00));
    add(1,0,16'h0040,0, 0,0,0,0,        mk(0,0,0,0,8'h11,8'h3C,0,16'h0030,8'h00));
    add(1,0,16'h0040,0, 0,0,0,0,        mk(1,0,0,1,8'h11,8'h22,0,16'h0040,8'h00));
    add(0,0,0,0,        1,0,16'h0050,0, mk(0,0,0,0,8'h11,8'h22,0,16'h0040,8'h00));
    add(0,0,0,0,        1,0,16'h0050,0, mk(0,1,1,0,8'h33,8'h22,0,16'h0050,8'h00));
    add(0,0,0,0,        0,0,0,0,        mk(0,0,0,0,8'h33,8'h22,0,16'h0050,8'h00));
    add(0,0,0,0,        0,0,0,0,        mk(0,0,0,1,8'h33,8'h44,0,16'h0050,8'h00));
    add(0,0,0,0,        0,0,0,0,        mk(0,0,0,0,8'h33,8'h44,0,16'h0050,8'h00));
    // top-of-range address
    add(1,1,16'hFFFF,8'hFF, 0,0,0,0, mk(1,0,0,0,8'h33,8'h44,1,16'hFFFF,8'hFF));
    add(0,0,0,0,            0,0,0,0, mk(0,0,0,0,8'h33,8'h44,0,16'hFFFF,8'hFF));
    add(1,0,16'hFFFF,8'h00, 0,0,0,0, mk(1,0,0,0,8'h33,8'h44,0,16'hFFFF,8'h00));
    add(0,0,0,0,            0,0,0,0, mk(0,0,0,0,8'h33,8'h44,0,16'hFFFF,8'h00));
    add(0,0,0,0,            0,0,0,0, mk(0,0,1,0,8'hFF,8'h44,0,16'hFFFF,8'h00));
    add(1,0,16'h0000,8'h00, 0,0,0,0, mk(1,0,0,0,8'hFF,8'h44,0,16'h0000,8'h00));
    add(0,0,0,0,            0,0,0,0, mk(0,0,0,0,8'hFF,8'h44,0,16'h0000,8'h00));
    add(0,0,0,0,            0,0,0,0, mk(0,0,1,0,8'h77,8'h44,0,16'h0000,8'h00));
    add(0,0,0,0,            0,0,0,0, mk(0,0,0,0,8'h77,8'h44,0,16'h0000,8'h00));
    // tie with A last served: B wins
    add(1,0,16'h0010,0, 1,0,16'h0000,0, mk(0,1,0,0,8'h77,8'h44,0,16'h0000,8'h00));
    add(1,0,16'h0010,0, 0,0,0,0,        mk(0,0,0,0,8'h77,8'h44,0,16'h0000,8'h00));
    add(1,0,16'h0010,0, 0,0,0,0,        mk(1,0,0,1,8'h77,8'h77,0,16'h0010,8'h00));
    add(0,0,0,0,        0,0,0,0,        mk(0,0,0,0,8'h77,8'h77,0,16'h0010,8'h00));
    add(0,0,0,0,        0,0,0,0,        mk(0,0,1,0,8'h5A,8'h77,0,16'h0010,8'h00));
    add(0,0,0,0,        0,0,0,0,        mk(0,0,0,0,8'h5A,8'h77,0,16'h0010,8'h00));

    drive(0,0,0,0, 0,0,0,0);
    reset_n = 1'b0;
    tick();
    tick();
    check("reset_state", outs(), '0);
    #2 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
            vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // reset asserted while a read is in READ
    drive(1,0,16'h0020,0, 0,0,0,0);
    tick();
    check("mid_grant", outs(), mk(1,0,0,0,8'h5A,8'h77,0,16'h0020,8'h00));
    drive(0,0,0,0, 0,0,0,0);
    tick();
    #2 reset_n = 1'b0;
    #1 check("async_reset", outs(), '0);
    tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset%0d", i), outs(), '0);
    end

    // first tie after reset goes to A
    drive(1,0,16'h0010,0, 1,0,16'h0030,0);
    tick();
    check("tie_after_reset", outs(), mk(1,0,0,0,8'h00,8'h00,0,16'h0010,8'h00));
    drive(0,0,0,0, 1,0,16'h0030,0);
    tick();
    tick();
    check("tie_a_data", outs(), mk(0,1,1,0,8'h5A,8'h00,0,16'h0030,8'h00));
    drive(0,0,0,0, 0,0,0,0);
    tick();
    tick();
    check("tie_b_data", outs(), mk(0,0,0,1,8'h5A,8'h22,0,16'h0030,8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
